jbyte_fetch: RTL and testbench
==============================

# jbyte_fetch

Java bytecode fetch and pre-decode unit sitting directly upstream of the JVM stack hardware attached to the Synapse316. It owns the Java program counter (JPC), reads 16-bit words from bytecode memory, extracts the opcode and its 0–2 inline operand bytes, and presents a complete instruction to the MCU's register file for dispatch. Once the MCU has executed the instruction against the stack RAM, it advances to the next instruction either sequentially or by a branch.

## Interface
- ADDR_W, 15, bytecode memory word-address width; JPC is a 16-bit byte address.
- sysclk  in  1  clock.
- sysreset  in  1  reset, asynchronous, active-high.
- bc_addr  out  ADDR_W  word address, driven as jpc[ADDR_W:1] for the word in flight.
- bc_req  out  1  fetch request; held with bc_addr stable until bc_ready.
- bc_data  in  16  bytecode word, big-endian: [15:8] is the even byte, [7:0] the odd byte.
- bc_ready  in  1  bc_data is valid for bc_addr this cycle; may rise the same cycle as bc_req.
- ld_jpc  in  1  absolute jump: jpc <= jpc_in and flush.
- jpc_in  in  16  absolute target, taken from r_load_data.
- adv  in  1  sequential advance: jpc <= jpc + len.
- adv_br  in  1  relative branch: jpc <= jpc + operand, signed.
- jpc  out  16  byte address of the current opcode.
- opcode  out  8  current opcode.
- operand  out  16  decoded operand.
- len  out  2  instruction length in bytes (1–3).
- insn_valid  out  1  opcode, operand and len are valid.
- illegal  out  1  current opcode is unsupported.

## Operation
- States: IDLE, FETCH0, FETCH1, VALID, ILLEGAL. After reset the block is in IDLE with jpc=0; it leaves IDLE only on ld_jpc.
- **FETCH0**: request word jpc[15:1].
  - Even jpc: opcode=hi byte, b1=lo byte.
  - Odd jpc: opcode=lo byte; hi byte discarded.
  - Then look up LEN_TABLE[opcode]:
    - 0 → ILLEGAL.
    - Bytes already held ≥ len → VALID.
    - Otherwise → FETCH1.
- **FETCH1**: request word jpc[15:1]+1, capturing the remaining 1–2 bytes, then go to VALID. At most two words are ever fetched.
- **Length table** (package constant):
  - Length 2: 0x10 bipush, 0x12 ldc, 0x15–0x19 loads, 0x36–0x3a stores, 0xbc newarray.
  - Length 3: 0x11 sipush, 0x13 ldc_w, 0x84 iinc, 0x99–0xa8 branches, 0xb2–0xb8 field/invoke, 0xbb new.
  - Length 0 (unsupported): 0xa9–0xab, 0xb9, 0xba, 0xc4, 0xc5, 0xc8, 0xc9, 0xcb–0xff.
  - All others: length 1.
- **Operand decode**:
  - len 1: operand=0.
  - len 2, bipush: operand=sign-extended b1.
  - len 2, other opcodes: operand=zero-extended b1.
  - len 3: operand={b1,b2}.
- **VALID**: outputs are held stable.
  - adv: jpc <= jpc+len, go to FETCH0.
  - adv_br: jpc <= jpc+operand (branch offset relative to the opcode address), go to FETCH0.
- **ILLEGAL**: illegal=1, insn_valid=0; the block stays here until ld_jpc.
- **Priority**: ld_jpc > adv_br > adv.
  - ld_jpc is accepted in any state and aborts a fetch in progress: bc_req drops for one cycle, the captured byte is discarded, and the block goes to FETCH0.
  - adv and adv_br are ignored outside VALID.
- **Arithmetic**: all JPC arithmetic is 16-bit and wraps mod 2^16; 0xffff+1 → 0x0000.

## Timing
- **Reset values**: jpc=0, opcode=0, operand=0, len=1, insn_valid=0, illegal=0, bc_req=0, bc_addr=0. Reset mid-fetch abandons the request immediately.
- **Capture**: a word is captured on the edge where bc_req && bc_ready. insn_valid and illegal are registered and rise on the edge after the final capture.
- **Zero-wait memory**, adv sampled at edge N:
  - 1-word instruction: insn_valid at N+2.
  - 2-word instruction: insn_valid at N+3.
- insn_valid drops on the edge that accepts adv, adv_br or ld_jpc.
- Each wait cycle (bc_ready low) adds one cycle of latency. bc_addr never changes while bc_req is high, except on ld_jpc or reset.

## Structure
- **Shared package** jvm_pkg: LEN_TABLE[256] 2-bit constant, opcode localparams (BIPUSH, SIPUSH, GOTO, …), and a state enum. The package is shared with the stack-machine decode.
- **Sub-module**: jbyte_len_rom, a combinational opcode→len lookup.

## Test plan
- **Reset/IDLE**: after reset, bc_req and insn_valid stay 0 for 10 cycles and jpc=0. Then ld_jpc=0x0000 with mem[0]=0x1005 → opcode=0x10, operand=0x0005, len=2, insn_valid at cycle 2.
- **Odd start, 3 bytes**: jpc=0x0001, words 0x0011 and 0x8001 → sipush, operand=0x8001, len=3; two bc_req handshakes; insn_valid after 3 cycles.
- **Sign extension and advance**: bipush 0xfe → operand=0xfffe. adv → jpc=prev+2.
- **Relative branch**: goto (0xa7) at jpc=0x0010 with offset 0xfff0, then adv_br → jpc=0x0000. Also check wrap: branch at 0xfffe with +4 → jpc=0x0002.
- **Abort and priority**: with bc_ready held low, ld_jpc=0x0040 mid-FETCH1 → bc_addr=0x0020, stale byte discarded. ld_jpc and adv asserted together → jpc=jpc_in.
- **Illegal**: opcode 0xaa (tableswitch) → illegal=1, insn_valid=0, adv ignored; ld_jpc recovers.

Source files
------------

// File: rtl/jvm_pkg.sv
// ---------------------------------------------------------------------------
// jvm_pkg
// Shared definitions for the Java bytecode front end and the stack-machine
// decode: opcode constants, the fetch FSM state type and the 256-entry
// instruction length table.
//   LEN_TABLE[op] : 2-bit length in bytes (1..3); 0 marks an opcode this
//                   hardware does not execute.
// ---------------------------------------------------------------------------
package jvm_pkg;

   // Opcodes referenced by the front end and the stack decode
   localparam logic [7:0] NOP          = 8'h00;
   localparam logic [7:0] BIPUSH       = 8'h10;
   localparam logic [7:0] SIPUSH       = 8'h11;
   localparam logic [7:0] LDC          = 8'h12;
   localparam logic [7:0] LDC_W        = 8'h13;
   localparam logic [7:0] ILOAD        = 8'h15;
   localparam logic [7:0] ISTORE       = 8'h36;
   localparam logic [7:0] IINC         = 8'h84;
   localparam logic [7:0] IFEQ         = 8'h99;
   localparam logic [7:0] GOTO         = 8'ha7;
   localparam logic [7:0] JSR          = 8'ha8;
   localparam logic [7:0] TABLESWITCH  = 8'haa;
   localparam logic [7:0] LOOKUPSWITCH = 8'hab;
   localparam logic [7:0] NEW          = 8'hbb;
   localparam logic [7:0] NEWARRAY     = 8'hbc;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH0  = 3'd1,
      ST_FETCH1  = 3'd2,
      ST_VALID   = 3'd3,
      ST_ILLEGAL = 3'd4
   } jstate_t;

   // Length of one opcode; used only to build LEN_TABLE at elaboration.
   function automatic logic [1:0] f_len_of(input logic [7:0] op);
      logic [1:0] l;
      l = 2'd1;
      if (op inside {8'h10, 8'h12, [8'h15:8'h19], [8'h36:8'h3a], 8'hbc})
         l = 2'd2;
      if (op inside {8'h11, 8'h13, 8'h84, [8'h99:8'ha8], [8'hb2:8'hb8], 8'hbb})
         l = 2'd3;
      // Variable-length and unimplemented opcodes (switches, invokeinterface,
      // invokedynamic, wide, multianewarray, goto_w/jsr_w, reserved range)
      if (op inside {[8'ha9:8'hab], 8'hb9, 8'hba, 8'hc4, 8'hc5, 8'hc8, 8'hc9,
                     [8'hcb:8'hff]})
         l = 2'd0;
      return l;
   endfunction

   function automatic logic [255:0][1:0] f_build_len_table();
      logic [255:0][1:0] t;
      for (int i = 0; i < 256; i++) begin
         t[i] = f_len_of(8'(i));
      end
      return t;
   endfunction

   localparam logic [255:0][1:0] LEN_TABLE = f_build_len_table();

endpackage

// File: rtl/jbyte_len_rom.sv
// ---------------------------------------------------------------------------
// jbyte_len_rom
// Combinational opcode -> instruction length lookup.
//   i_opcode : opcode byte
//   o_len    : length in bytes (1..3), 0 for an unsupported opcode
// ---------------------------------------------------------------------------
module jbyte_len_rom
   import jvm_pkg::*;
(
   input  logic [7:0] i_opcode,
   output logic [1:0] o_len
);

   assign o_len = LEN_TABLE[i_opcode];

endmodule

// File: rtl/jbyte_fetch.sv
// ---------------------------------------------------------------------------
// jbyte_fetch
// Java bytecode fetch and pre-decode. Owns the JPC, fetches one or two
// 16-bit big-endian words from bytecode memory, extracts opcode and up to
// two operand bytes and presents a complete instruction to the MCU.
//   sysclk, sysreset   : clock, asynchronous active-high reset
//   bc_addr/bc_req     : word request, held stable until bc_ready
//   bc_data/bc_ready   : returned word and its strobe
//   ld_jpc/jpc_in      : absolute jump (highest priority, any state)
//   adv_br             : jpc += operand (signed), only in VALID
//   adv                : jpc += len, only in VALID
//   jpc/opcode/operand/len : current instruction
//   insn_valid/illegal : instruction ready / opcode unsupported
// ---------------------------------------------------------------------------
module jbyte_fetch
   import jvm_pkg::*;
#(
   parameter int ADDR_W = 15
) (
   input  logic              sysclk,
   input  logic              sysreset,
   output logic [ADDR_W-1:0] bc_addr,
   output logic              bc_req,
   input  logic [15:0]       bc_data,
   input  logic              bc_ready,
   input  logic              ld_jpc,
   input  logic [15:0]       jpc_in,
   input  logic              adv,
   input  logic              adv_br,
   output logic [15:0]       jpc,
   output logic [7:0]        opcode,
   output logic [15:0]       operand,
   output logic [1:0]        len,
   output logic              insn_valid,
   output logic              illegal
);

   jstate_t           r_state,      w_nxt_state;
   logic [15:0]       r_jpc,        w_nxt_jpc;
   logic [7:0]        r_opcode,     w_nxt_opcode;
   logic [7:0]        r_b1,         w_nxt_b1;
   logic [15:0]       r_operand,    w_nxt_operand;
   logic [1:0]        r_len,        w_nxt_len;
   logic              r_bc_req,     w_nxt_bc_req;
   logic [ADDR_W-1:0] r_bc_addr,    w_nxt_bc_addr;
   logic              r_insn_valid, w_nxt_insn_valid;
   logic              r_illegal,    w_nxt_illegal;

   logic              w_capture;
   logic [7:0]        w_fetch_op;
   logic [1:0]        w_rom_len;
   logic [1:0]        w_held;
   logic [7:0]        w_f1_b1;
   logic [7:0]        w_f1_b2;

   // Operand formation from the opcode, its length and the inline bytes.
   function automatic logic [15:0] f_operand(input logic [7:0] op,
                                             input logic [1:0] l,
                                             input logic [7:0] b1,
                                             input logic [7:0] b2);
      logic signed [7:0]  s_b1;
      logic signed [15:0] s_ext;
      logic [15:0]        res;
      s_b1  = b1;
      s_ext = 16'(s_b1);
      res   = 16'h0000;
      case (l)
         2'd2:    res = (op == BIPUSH) ? s_ext : {8'h00, b1};
         2'd3:    res = {b1, b2};
         default: res = 16'h0000;
      endcase
      return res;
   endfunction

   assign w_capture  = r_bc_req & bc_ready;
   // Odd JPC: opcode is the low byte and the high byte belongs to the
   // previous instruction. Even JPC: the low byte is already operand b1.
   assign w_fetch_op = r_jpc[0] ? bc_data[7:0] : bc_data[15:8];
   assign w_held     = r_jpc[0] ? 2'd1 : 2'd2;
   // Second word: odd JPC still needs b1 (hi) and possibly b2 (lo);
   // even JPC holds b1 already and needs only b2 (hi).
   assign w_f1_b1    = r_jpc[0] ? bc_data[15:8] : r_b1;
   assign w_f1_b2    = r_jpc[0] ? bc_data[7:0]  : bc_data[15:8];

   jbyte_len_rom u_len_rom (
      .i_opcode (w_fetch_op),
      .o_len    (w_rom_len)
   );

   always_comb begin
      w_nxt_state   = r_state;
      w_nxt_jpc     = r_jpc;
      w_nxt_opcode  = r_opcode;
      w_nxt_b1      = r_b1;
      w_nxt_operand = r_operand;
      w_nxt_len     = r_len;
      w_nxt_bc_req  = r_bc_req;
      w_nxt_bc_addr = r_bc_addr;

      if (ld_jpc) begin
         // Abort anything in flight; the request reissues one cycle later.
         w_nxt_jpc     = jpc_in;
         w_nxt_state   = ST_FETCH0;
         w_nxt_bc_req  = 1'b0;
         w_nxt_bc_addr = jpc_in[ADDR_W:1];
      end else begin
         case (r_state)
            ST_FETCH0: begin
               if (!r_bc_req) begin
                  w_nxt_bc_req  = 1'b1;
                  w_nxt_bc_addr = r_jpc[ADDR_W:1];
               end else if (w_capture) begin
                  w_nxt_opcode = w_fetch_op;
                  w_nxt_b1     = bc_data[7:0];
                  if (w_rom_len == 2'd0) begin
                     w_nxt_state   = ST_ILLEGAL;
                     w_nxt_bc_req  = 1'b0;
                     w_nxt_operand = 16'h0000;
                  end else if (w_held >= w_rom_len) begin
                     w_nxt_state   = ST_VALID;
                     w_nxt_bc_req  = 1'b0;
                     w_nxt_len     = w_rom_len;
                     w_nxt_operand = f_operand(w_fetch_op, w_rom_len,
                                               bc_data[7:0], 8'h00);
                  end else begin
                     // Back-to-back request for the following word.
                     w_nxt_state   = ST_FETCH1;
                     w_nxt_len     = w_rom_len;
                     w_nxt_bc_addr = r_jpc[ADDR_W:1] + ADDR_W'(1);
                  end
               end
            end
            ST_FETCH1: begin
               if (w_capture) begin
                  w_nxt_state   = ST_VALID;
                  w_nxt_bc_req  = 1'b0;
                  w_nxt_b1      = w_f1_b1;
                  w_nxt_operand = f_operand(r_opcode, r_len, w_f1_b1, w_f1_b2);
               end
            end
            ST_VALID: begin
               if (adv_br) begin
                  w_nxt_jpc   = r_jpc + r_operand;
                  w_nxt_state = ST_FETCH0;
               end else if (adv) begin
                  w_nxt_jpc   = r_jpc + 16'(r_len);
                  w_nxt_state = ST_FETCH0;
               end
            end
            default: begin
               // IDLE and ILLEGAL wait for ld_jpc.
               w_nxt_state = r_state;
            end
         endcase
      end

      w_nxt_insn_valid = (w_nxt_state == ST_VALID);
      w_nxt_illegal    = (w_nxt_state == ST_ILLEGAL);
   end

   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         r_state      <= ST_IDLE;
         r_jpc        <= 16'h0000;
         r_opcode     <= 8'h00;
         r_b1         <= 8'h00;
         r_operand    <= 16'h0000;
         r_len        <= 2'd1;
         r_bc_req     <= 1'b0;
         r_bc_addr    <= '0;
         r_insn_valid <= 1'b0;
         r_illegal    <= 1'b0;
      end else begin
         r_state      <= w_nxt_state;
         r_jpc        <= w_nxt_jpc;
         r_opcode     <= w_nxt_opcode;
         r_b1         <= w_nxt_b1;
         r_operand    <= w_nxt_operand;
         r_len        <= w_nxt_len;
         r_bc_req     <= w_nxt_bc_req;
         r_bc_addr    <= w_nxt_bc_addr;
         r_insn_valid <= w_nxt_insn_valid;
         r_illegal    <= w_nxt_illegal;
      end
   end

   assign bc_addr    = r_bc_addr;
   assign bc_req     = r_bc_req;
   assign jpc        = r_jpc;
   assign opcode     = r_opcode;
   assign operand    = r_operand;
   assign len        = r_len;
   assign insn_valid = r_insn_valid;
   assign illegal    = r_illegal;

endmodule

// File: tb/tb_jbyte_fetch.sv
// ---------------------------------------------------------------------------
// tb_jbyte_fetch
// Directed and randomized bench for jbyte_fetch with a byte-level
// reference model of the bytecode stream.
// ---------------------------------------------------------------------------
module tb_jbyte_fetch;

   logic        sysclk = 1'b0;
   logic        sysreset;
   logic [14:0] bc_addr;
   logic        bc_req;
   logic [15:0] bc_data;
   logic        bc_ready;
   logic        ld_jpc;
   logic [15:0] jpc_in;
   logic        adv;
   logic        adv_br;
   logic [15:0] jpc;
   logic [7:0]  opcode;
   logic [15:0] operand;
   logic [1:0]  len;
   logic        insn_valid;
   logic        illegal;

   logic [15:0] mem [0:32767];
   int          n_checks = 0;
   int          n_errors = 0;
   int          hs_cnt   = 0;
   int          addr_viol = 0;
   logic        p_req, p_ready, p_ld;
   logic [14:0] p_addr;

   always #5 sysclk = ~sysclk;

   assign bc_data = mem[bc_addr];

   jbyte_fetch #(.ADDR_W(15)) dut (
      .sysclk     (sysclk),
      .sysreset   (sysreset),
      .bc_addr    (bc_addr),
      .bc_req     (bc_req),
      .bc_data    (bc_data),
      .bc_ready   (bc_ready),
      .ld_jpc     (ld_jpc),
      .jpc_in     (jpc_in),
      .adv        (adv),
      .adv_br     (adv_br),
      .jpc        (jpc),
      .opcode     (opcode),
      .operand    (operand),
      .len        (len),
      .insn_valid (insn_valid),
      .illegal    (illegal)
   );

   // Handshake counter and request-stability monitor (pre-edge values).
   always @(posedge sysclk) begin
      if (bc_req && bc_ready) hs_cnt <= hs_cnt + 1;
      if (p_req === 1'b1 && p_ready === 1'b0 && p_ld === 1'b0 && sysreset === 1'b0 &&
          bc_req === 1'b1 && bc_addr !== p_addr)
         addr_viol <= addr_viol + 1;
      p_req   <= bc_req;
      p_ready <= bc_ready;
      p_ld    <= ld_jpc;
      p_addr  <= bc_addr;
   end

   // ---------------- reference model ----------------
   function automatic int m_len(input logic [7:0] op);
      if (op == 8'h10 || op == 8'h12 || (op >= 8'h15 && op <= 8'h19) ||
          (op >= 8'h36 && op <= 8'h3a) || op == 8'hbc) return 2;
      if (op == 8'h11 || op == 8'h13 || op == 8'h84 || (op >= 8'h99 && op <= 8'ha8) ||
          (op >= 8'hb2 && op <= 8'hb8) || op == 8'hbb) return 3;
      if ((op >= 8'ha9 && op <= 8'hab) || op == 8'hb9 || op == 8'hba || op == 8'hc4 ||
          op == 8'hc5 || op == 8'hc8 || op == 8'hc9 || op >= 8'hcb) return 0;
      return 1;
   endfunction

   function automatic logic [7:0] m_byte(input logic [15:0] a);
      logic [15:0] w;
      w = mem[a[15:1]];
      return a[0] ? w[7:0] : w[15:8];
   endfunction

   function automatic logic [15:0] m_operand(input logic [15:0] a);
      logic [7:0] op, b1, b2;
      int         l;
      op = m_byte(a);
      b1 = m_byte(a + 16'd1);
      b2 = m_byte(a + 16'd2);
      l  = m_len(op);
      if (l == 2) return (op == 8'h10) ? {{8{b1[7]}}, b1} : {8'h00, b1};
      if (l == 3) return {b1, b2};
      return 16'h0000;
   endfunction

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic cmd(input logic l, input logic [15:0] tgt, input logic a, input logic ab);
      ld_jpc = l; jpc_in = tgt; adv = a; adv_br = ab;
      step();
      ld_jpc = 1'b0; adv = 1'b0; adv_br = 1'b0;
   endtask

   task automatic wait_done(input bit rnd, output int lat);
      lat = 0;
      while (!(insn_valid || illegal) && lat < 200) begin
         bc_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         step();
         lat++;
      end
      bc_ready = 1'b1;
      if (lat >= 200) chk("timeout", 32'(lat), 32'd0);
   endtask

   initial begin
      int          lat;
      int          hs_base;
      bit          seen;
      logic [15:0] mjpc;
      logic [15:0] mopnd;
      logic [7:0]  mop;
      int          ml;
      int          act;

      for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
      sysreset = 1'b1; bc_ready = 1'b1; ld_jpc = 1'b0; jpc_in = 16'h0000;
      adv = 1'b0; adv_br = 1'b0;
      repeat (3) step();
      chk("rst_jpc", 32'(jpc), 32'h0);
      chk("rst_opcode", 32'(opcode), 32'h0);
      chk("rst_operand", 32'(operand), 32'h0);
      chk("rst_len", 32'(len), 32'd1);
      chk("rst_valid", 32'(insn_valid), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_req", 32'(bc_req), 32'd0);
      chk("rst_addr", 32'(bc_addr), 32'h0);

      sysreset = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         step();
         if (bc_req || insn_valid) seen = 1'b1;
      end
      chk("idle_quiet", 32'(seen), 32'd0);
      chk("idle_jpc", 32'(jpc), 32'h0);

      // bipush 5 at 0x0000
      mem[0] = 16'h1005;
      cmd(1'b1, 16'h0000, 1'b0, 1'b0);
      wait_done(1'b0, lat);
      chk("first_lat", 32'(lat), 32'd2);
      chk("first_op", 32'(opcode), 32'h10);
      chk("first_opnd", 32'(operand), 32'h0005);
      chk("first_len", 32'(len), 32'd2);

      // odd start, sipush 0x8001 split over two words
      mem[0] = 16'h0011; mem[1] = 16'h8001;
      hs_base = hs_cnt;
      cmd(1'b1, 16'h0001, 1'b0, 1'b0);
      wait_done(1'b0, lat);
      chk("odd_lat", 32'(lat), 32'd3);
      chk("odd_hs", 32'(hs_cnt - hs_base), 32'd2);
      chk("odd_op", 32'(opcode), 32'h11);
      chk("odd_opnd", 32'(operand), 32'h8001);
      chk("odd_len", 32'(len), 32'd3);

      // bipush -2, then sequential advance onto a nop
      mem[16'h80] = 16'h10fe; mem[16'h81] = 16'h0000;
      cmd(1'b1, 16'h0100, 1'b0, 1'b0);
      wait_done(1'b0, lat);
      chk("bipush_opnd", 32'(operand), 32'hfffe);
      cmd(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("adv_jpc", 32'(jpc), 32'h0102);
      chk("adv_drop", 32'(insn_valid), 32'd0);
      wait_done(1'b0, lat);
      chk("adv_lat", 32'(lat), 32'd2);
      chk("adv_len", 32'(len), 32'd1);

      // goto -16 from 0x0010
      mem[8] = 16'ha7ff; mem[9] = 16'hf000;
      cmd(1'b1, 16'h0010, 1'b0, 1'b0);
      wait_done(1'b0, lat);
      chk("goto_opnd", 32'(operand), 32'hfff0);
      cmd(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("goto_jpc", 32'(jpc), 32'h0000);
      wait_done(1'b0, lat);

      // branch +4 at 0xfffe wraps to 0x0002
      mem[15'h7fff] = 16'ha700; mem[0] = 16'h0400; mem[1] = 16'h0000;
      cmd(1'b1, 16'hfffe, 1'b0, 1'b0);
      wait_done(1'b0, lat);
      chk("wrap_lat", 32'(lat), 32'd3);
      chk("wrap_opnd", 32'(operand), 32'h0004);
      cmd(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("wrap_jpc", 32'(jpc), 32'h0002);
      wait_done(1'b0, lat);

      // abort in FETCH1 with the memory stalled
      mem[16'h100] = 16'h1100; mem[16'h101] = 16'h2200; mem[16'h20] = 16'h107b;
      bc_ready = 1'b0;
      cmd(1'b1, 16'h0200, 1'b0, 1'b0);
      step();
      bc_ready = 1'b1;
      step();
      bc_ready = 1'b0;
      step();
      chk("f1_req", 32'(bc_req), 32'd1);
      chk("f1_addr", 32'(bc_addr), 32'h101);
      cmd(1'b1, 16'h0040, 1'b0, 1'b0);
      chk("abort_drop", 32'(bc_req), 32'd0);
      chk("abort_jpc", 32'(jpc), 32'h0040);
      step();
      chk("abort_req", 32'(bc_req), 32'd1);
      chk("abort_addr", 32'(bc_addr), 32'h020);
      wait_done(1'b1, lat);
      chk("abort_op", 32'(opcode), 32'h10);
      chk("abort_opnd", 32'(operand), 32'h007b);

      // ld_jpc wins over adv/adv_br
      mem[16'h180] = 16'h0000;
      cmd(1'b1, 16'h0300, 1'b1, 1'b1);
      chk("prio_jpc", 32'(jpc), 32'h0300);
      wait_done(1'b0, lat);
      chk("prio_valid", 32'(insn_valid), 32'd1);

      // tableswitch is unsupported
      mem[16'h200] = 16'haa00;
      cmd(1'b1, 16'h0400, 1'b0, 1'b0);
      wait_done(1'b0, lat);
      chk("ill_flag", 32'(illegal), 32'd1);
      chk("ill_valid", 32'(insn_valid), 32'd0);
      chk("ill_op", 32'(opcode), 32'haa);
      cmd(1'b0, 16'h0000, 1'b1, 1'b0);
      step();
      chk("ill_hold", 32'(illegal), 32'd1);
      chk("ill_jpc", 32'(jpc), 32'h0400);
      cmd(1'b1, 16'h0300, 1'b0, 1'b0);
      wait_done(1'b0, lat);
      chk("ill_recover", 32'({insn_valid, illegal}), 32'b10);

      // randomized stream against the byte-level model
      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
      mjpc = 16'($urandom);
      cmd(1'b1, mjpc, 1'b0, 1'b0);
      for (int it = 0; it < 60; it++) begin
         wait_done(1'b1, lat);
         mop   = m_byte(mjpc);
         ml    = m_len(mop);
         mopnd = m_operand(mjpc);
         chk("rnd_jpc", 32'(jpc), 32'(mjpc));
         if (ml == 0) begin
            chk("rnd_ill", 32'({insn_valid, illegal}), 32'b01);
            mjpc = 16'($urandom);
            cmd(1'b1, mjpc, 1'b0, 1'b0);
         end else begin
            chk("rnd_valid", 32'({insn_valid, illegal}), 32'b10);
            chk("rnd_op", 32'(opcode), 32'(mop));
            chk("rnd_len", 32'(len), 32'(ml));
            chk("rnd_opnd", 32'(operand), 32'(mopnd));
            act = $urandom_range(0, 9);
            if (act < 6) begin
               mjpc = mjpc + 16'(ml);
               cmd(1'b0, 16'h0000, 1'b1, 1'b0);
            end else if (act < 9) begin
               mjpc = mjpc + mopnd;
               cmd(1'b0, 16'h0000, $urandom_range(0, 1) != 0, 1'b1);
            end else begin
               mjpc = 16'($urandom);
               cmd(1'b1, mjpc, 1'b1, 1'b0);
            end
         end
      end
      step();
      chk("addr_stable", 32'(addr_viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
